// File: rtl/xor_parity_sched.sv
// xor_parity_sched
//
// Shares one XOR-fold parity engine between NUM_REQ requesters. A
// round-robin arbiter accepts one DATA_W-bit word at a time. The word is
// then folded SLICE_W bits per cycle over NSLICE = DATA_W/SLICE_W cycles.
// The parity bit and the owner's ID are returned over a valid/ready
// result channel.
//
// Parameters:
//   NUM_REQ  number of requesters (2..16)
//   DATA_W   request word width (integer multiple of SLICE_W)
//   SLICE_W  bits folded per engine cycle
//   ID_W     requester ID width
//
// Ports:
//   clk         clock
//   rst_b       synchronous reset, active-low
//   req_valid   per-requester request valid
//   req_data    request words, requester i at [i*DATA_W +: DATA_W]
//   req_ready   one-hot grant/accept strobe (combinational, IDLE only)
//   res_valid   result valid
//   res_ready   result consumer ready
//   res_parity  XOR of all DATA_W bits of the accepted word
//   res_id      requester that owns the result
//   busy        high whenever the scheduler is not IDLE
module xor_parity_sched #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_b,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      res_parity,
  output logic [ID_W-1:0]           res_id,
  output logic                      busy
);

  localparam int NSLICE = DATA_W / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);
  localparam logic [ID_W-1:0]  PTR_RST    = ID_W'(NUM_REQ - 1);

  // Reject unsupported configurations at elaboration time.
  generate
    if (DATA_W % SLICE_W != 0) begin : g_bad_slice
      $error("xor_parity_sched: DATA_W must be a multiple of SLICE_W");
    end
    if (NUM_REQ < 2) begin : g_bad_req
      $error("xor_parity_sched: NUM_REQ must be at least 2");
    end
  endgenerate

  // One engine step: XOR-reduce a single slice. This reduction tree is
  // the part that maps onto the shared XOR cells.
  function automatic logic fold_slice(input logic [SLICE_W-1:0] s);
    return ^s;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [DATA_W-1:0]   data_q;
  logic                acc;
  logic [CNT_W-1:0]    slice_cnt;
  logic [ID_W-1:0]     last_grant;

  logic                grant_any;
  logic [ID_W-1:0]     grant_id;
  logic                accept;
  logic                last_slice;
  logic                slice_par;

  // Round-robin search: first valid requester above last_grant, with
  // wrap-around. The pointer itself only moves on acceptance.
  always_comb begin : arb
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
  end

  assign slice_par  = fold_slice(data_q[int'(slice_cnt)*SLICE_W +: SLICE_W]);
  assign last_slice = (state == RUN) && (slice_cnt == LAST_SLICE);
  assign busy       = (state != IDLE);

  // Next-state and grant strobe. A grant is never shown while reset is
  // asserted, so nothing can look accepted on a reset edge.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any && rst_b) begin
          req_ready[grant_id] = 1'b1;
          accept              = 1'b1;
          state_nxt           = RUN;
        end
      end
      RUN: begin
        if (last_slice) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        // res_valid is always high in DONE, so res_ready alone completes
        // the handshake. No re-grant in this cycle.
        if (res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath and result registers. A reset discards any in-flight word.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      data_q     <= '0;
      acc        <= 1'b0;
      slice_cnt  <= '0;
      last_grant <= PTR_RST;
      res_valid  <= 1'b0;
      res_parity <= 1'b0;
      res_id     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            data_q     <= req_data[int'(grant_id)*DATA_W +: DATA_W];
            res_id     <= grant_id;
            last_grant <= grant_id;
            acc        <= 1'b0;
            slice_cnt  <= '0;
          end
        end
        RUN: begin
          acc <= acc ^ slice_par;
          if (last_slice) begin
            // The final slice is folded straight into the result so that
            // res_valid rises on the same edge.
            slice_cnt  <= '0;
            res_parity <= acc ^ slice_par;
            res_valid  <= 1'b1;
          end else begin
            slice_cnt <= slice_cnt + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xor_parity_sched.sv
module tb_xor_parity_sched;

  logic         clk;
  logic         rst_b;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         res_valid;
  logic         res_ready;
  logic         res_parity;
  logic [1:0]   res_id;
  logic         busy;

  int vecs = 0;
  int miss = 0;
  int cyc  = 0;
  int last_acc = 0;

  xor_parity_sched dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_parity (res_parity),
    .res_id     (res_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, vectors=%0d", vecs);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic         rst;
    logic [3:0]   valid;
    logic [127:0] data;
    int           exp_id;
    logic         exp_par;
    int           gap;
    logic         scrub;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_b     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    @(posedge clk); #1;
    rst_b = 1'b1;
  endtask

  // One complete transaction with res_ready held high: grant, fold,
  // result, handshake. Returns one tick after the handshake edge.
  task automatic do_txn(input int tag, input int exp_id, input logic exp_par,
                        input int exp_gap, input logic scrub);
    int n;
    int acc_c;
    #1;
    n = 0;
    while (req_ready == 4'b0000 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("t%0d_grant", tag), 32'(req_ready), 32'(1) << exp_id);
    @(posedge clk); #1;
    acc_c = cyc;
    check($sformatf("t%0d_busy_run", tag), 32'({busy, req_ready}), 32'({1'b1, 4'b0000}));
    if (exp_gap > 0) begin
      check($sformatf("t%0d_gap", tag), 32'(acc_c - last_acc), 32'(exp_gap));
    end
    last_acc = acc_c;
    if (scrub) begin
      req_valid = '0;
      req_data  = '0;
    end
    n = 0;
    while (!res_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("t%0d_latency", tag), 32'(cyc - acc_c), 32'd4);
    check($sformatf("t%0d_result", tag), 32'({res_parity, res_id}),
          32'({exp_par, 2'(exp_id)}));
    @(posedge clk); #1;
    check($sformatf("t%0d_handshake", tag), 32'({res_valid, busy}), 32'd0);
  endtask

  initial begin
    logic [127:0] rr;
    int n;
    rr = {32'h0101_0101, 32'h0000_0003, 32'h8000_0000, 32'hFFFF_FFFF};

    //           rst   valid    data                                  id par gap scrub
    tbl[0]  = '{1'b1, 4'b0001, {96'h0, 32'h0000_0001},               0, 1'b1, 0, 1'b0};
    tbl[1]  = '{1'b1, 4'b1111, rr,                                   0, 1'b0, 0, 1'b0};
    tbl[2]  = '{1'b0, 4'b1111, rr,                                   1, 1'b1, 6, 1'b0};
    tbl[3]  = '{1'b0, 4'b1111, rr,                                   2, 1'b0, 6, 1'b0};
    tbl[4]  = '{1'b0, 4'b1111, rr,                                   3, 1'b0, 6, 1'b0};
    tbl[5]  = '{1'b0, 4'b1111, rr,                                   0, 1'b0, 6, 1'b0};
    tbl[6]  = '{1'b0, 4'b0100, {32'h0, 32'h0000_0007, 64'h0},        2, 1'b1, 6, 1'b0};
    tbl[7]  = '{1'b0, 4'b0011, {64'h0, 32'h0000_0010, 32'h0000_0003}, 0, 1'b0, 6, 1'b0};
    tbl[8]  = '{1'b0, 4'b0011, {64'h0, 32'h0000_0010, 32'h0000_0003}, 1, 1'b1, 6, 1'b0};
    tbl[9]  = '{1'b0, 4'b1001, {32'h0000_0E00, 64'h0, 32'h0000_0005}, 3, 1'b1, 6, 1'b0};
    tbl[10] = '{1'b0, 4'b0001, {96'h0, 32'h0000_0007},               0, 1'b1, 6, 1'b1};

    // Reset state, with requests present to show no grant leaks out.
    rst_b     = 1'b0;
    req_valid = 4'b1111;
    req_data  = rr;
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'({res_valid, res_parity, res_id, busy, req_ready}), 32'd0);
    rst_b     = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
    check("idle_no_req", 32'({busy, req_ready}), 32'd0);

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].rst) do_reset();
      req_valid = tbl[i].valid;
      req_data  = tbl[i].data;
      do_txn(i, tbl[i].exp_id, tbl[i].exp_par, tbl[i].gap, tbl[i].scrub);
    end

    // Backpressure: result held while requester 1 waits.
    do_reset();
    res_ready = 1'b0;
    req_valid = 4'b0001;
    req_data  = {96'h0, 32'h0000_0007};
    #1;
    check("bp_grant0", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 4'b0010;
    req_data  = {64'h0, 32'h0000_0003, 32'h0000_0007};
    n = 0;
    while (!res_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_hold%0d", i),
            32'({res_valid, res_parity, res_id, req_ready, busy}),
            32'({1'b1, 1'b1, 2'd0, 4'b0000, 1'b1}));
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    #1;
    check("bp_no_regrant", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    check("bp_after_hs", 32'({res_valid, req_ready}), 32'({1'b0, 4'b0010}));
    do_txn(100, 1, 1'b0, 0, 1'b0);

    // Reset two edges after acceptance: word discarded, pointer restored.
    do_reset();
    req_valid = 4'b0100;
    req_data  = {32'h0, 32'h0000_0001, 64'h0};
    #1;
    check("mr_grant2", 32'(req_ready), 32'h4);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    rst_b = 1'b0;
    @(posedge clk); #1;
    check("mr_after_rst", 32'({busy, res_valid}), 32'd0);
    rst_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check($sformatf("mr_quiet%0d", i), 32'({busy, res_valid}), 32'd0);
    end
    req_valid = 4'b1001;
    req_data  = {32'h0000_0001, 64'h0, 32'h0000_0003};
    do_txn(200, 0, 1'b0, 0, 1'b0);
    do_txn(201, 3, 1'b1, 6, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
